// File: rtl/ibex_xif_pkg.sv
// Shared types and defaults for the eXtension-IF register-file write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ibex_xif_pkg;

    // One pending XIF register-file write as held in the arbiter buffer
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } xif_rf_wr_t;

    localparam int unsigned XifMaxOutstandingDefault = 4;

endpackage

// File: rtl/ibex_xif_rf_scoreboard.sv
// Pending-rd scoreboard: one busy bit per GPR for XIF writes not yet retired.
// Latency: set/clear visible on busy_o the cycle after the request.
// Backpressure: none; set and clear are accepted every cycle, set wins on the same rd.
module ibex_xif_rf_scoreboard (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        set_i,
    input  logic [4:0]  set_rd_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_rd_i,
    output logic [31:0] busy_o
);
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Next busy vector: clear first so a same-rd set overrides it; x0 never tracked
    always_comb begin
        set_mask = set_i ? (32'd1 << set_rd_i) : 32'd0;
        clr_mask = clr_i ? (32'd1 << clr_rd_i) : 32'd0;
        busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    // Busy register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ibex_xif_rf_wr_arbiter.sv
// Shares the RF write port between core writeback (priority) and buffered XIF results.
// Latency: an accepted XIF result writes the RF one cycle later at the earliest.
// Backpressure: x_result_ready_o drops while the one-entry buffer is full and blocked by core writes.
module ibex_xif_rf_wr_arbiter
    import ibex_xif_pkg::*;
#(
    parameter int unsigned MaxOutstanding = XifMaxOutstandingDefault,
    parameter int unsigned StarveLimit    = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 x_issue_accept_i,
    input  logic                                 x_issue_we_i,
    input  logic [4:0]                           x_issue_rd_i,
    output logic                                 issue_ready_o,
    input  logic                                 x_result_valid_i,
    output logic                                 x_result_ready_o,
    input  logic                                 x_result_we_i,
    input  logic [4:0]                           x_result_rd_i,
    input  logic [31:0]                          x_result_data_i,
    input  logic                                 core_rf_we_i,
    input  logic [4:0]                           core_rf_waddr_i,
    input  logic [31:0]                          core_rf_wdata_i,
    output logic                                 rf_we_o,
    output logic [4:0]                           rf_waddr_o,
    output logic [31:0]                          rf_wdata_o,
    output logic [31:0]                          rf_busy_o,
    output logic                                 stall_id_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);
    localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned WaitW = $clog2(StarveLimit + 1);
    localparam logic [OutW-1:0]  OutMax    = OutW'(MaxOutstanding);
    localparam logic [WaitW-1:0] WaitMax   = WaitW'(StarveLimit);
    localparam logic [WaitW-1:0] WaitStall = WaitW'(StarveLimit - 1);

    logic             buf_valid_q;
    xif_rf_wr_t       buf_q;
    logic [OutW-1:0]  out_q;
    logic [WaitW-1:0] wait_q;
    logic             stall_q;

    logic drain;
    logic blocked;
    logic result_hs;
    logic grant_core;
    logic grant_buf;
    logic sb_set;
    logic sb_clr;

    // Handshake, drain and write-port mux; core writeback always wins the port
    always_comb begin
        drain            = rst_ni & buf_valid_q & ~core_rf_we_i;
        blocked          = buf_valid_q & core_rf_we_i;
        x_result_ready_o = rst_ni & (~buf_valid_q | drain);
        result_hs        = x_result_valid_i & x_result_ready_o;
        issue_ready_o    = rst_ni & (out_q < OutMax);
        grant_core       = core_rf_we_i;
        grant_buf        = drain & buf_q.we & (buf_q.rd != 5'd0);
        sb_set           = x_issue_accept_i & x_issue_we_i & (x_issue_rd_i != 5'd0);
        sb_clr           = drain & buf_q.we;
        rf_we_o          = 1'b0;
        rf_waddr_o       = '0;
        rf_wdata_o       = '0;
        if (grant_core) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = core_rf_waddr_i;
            rf_wdata_o = core_rf_wdata_i;
        end else if (grant_buf) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = buf_q.rd;
            rf_wdata_o = buf_q.data;
        end
    end

    // One-entry result buffer; load and drain in the same cycle keeps full throughput
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else if (result_hs) begin
            buf_valid_q <= 1'b1;
            buf_q       <= '{we: x_result_we_i, rd: x_result_rd_i, data: x_result_data_i};
        end else if (drain) begin
            buf_valid_q <= 1'b0;
        end
    end

    // In-flight offload count: issue accept in, result handshake out, saturating
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else if (x_issue_accept_i && !result_hs && (out_q != OutMax)) begin
            out_q <= out_q + 1'b1;
        end else if (!x_issue_accept_i && result_hs && (out_q != '0)) begin
            out_q <= out_q - 1'b1;
        end
    end

    // Starvation tracking: count blocked cycles, stall ID until the buffer drains
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            if (drain) begin
                wait_q <= '0;
            end else if (blocked && (wait_q != WaitMax)) begin
                wait_q <= wait_q + 1'b1;
            end
            if (blocked && (wait_q >= WaitStall)) begin
                stall_q <= 1'b1;
            end else if (drain) begin
                stall_q <= 1'b0;
            end
        end
    end

    ibex_xif_rf_scoreboard u_scoreboard (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_i    (sb_set),
        .set_rd_i (x_issue_rd_i),
        .clr_i    (sb_clr),
        .clr_rd_i (buf_q.rd),
        .busy_o   (rf_busy_o)
    );

    assign stall_id_o    = stall_q;
    assign outstanding_o = out_q;

    // The write port is granted to at most one source
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({grant_core, grant_buf}));

    // No offload to an rd that still has a pending XIF write, unless it retires this cycle
    a_no_waw: assert property (@(posedge clk_i) disable iff (!rst_ni)
        sb_set |-> (!rf_busy_o[x_issue_rd_i] || (sb_clr && (buf_q.rd == x_issue_rd_i))));

    // No result without an outstanding offload, no offload beyond the limit
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (result_hs && !x_issue_accept_i) |-> (out_q != '0));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (x_issue_accept_i && !result_hs) |-> (out_q != OutMax));

endmodule

// File: tb/tb_ibex_xif_rf_wr_arbiter.sv
// Directed bench: expected RF writes queued by stimulus, checked by a negedge monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_ibex_xif_rf_wr_arbiter;
    logic        clk_i;
    logic        rst_ni;
    logic        x_issue_accept_i;
    logic        x_issue_we_i;
    logic [4:0]  x_issue_rd_i;
    logic        issue_ready_o;
    logic        x_result_valid_i;
    logic        x_result_ready_o;
    logic        x_result_we_i;
    logic [4:0]  x_result_rd_i;
    logic [31:0] x_result_data_i;
    logic        core_rf_we_i;
    logic [4:0]  core_rf_waddr_i;
    logic [31:0] core_rf_wdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] rf_busy_o;
    logic        stall_id_o;
    logic [2:0]  outstanding_o;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    ibex_xif_rf_wr_arbiter #(
        .MaxOutstanding (4),
        .StarveLimit    (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .x_issue_accept_i (x_issue_accept_i),
        .x_issue_we_i     (x_issue_we_i),
        .x_issue_rd_i     (x_issue_rd_i),
        .issue_ready_o    (issue_ready_o),
        .x_result_valid_i (x_result_valid_i),
        .x_result_ready_o (x_result_ready_o),
        .x_result_we_i    (x_result_we_i),
        .x_result_rd_i    (x_result_rd_i),
        .x_result_data_i  (x_result_data_i),
        .core_rf_we_i     (core_rf_we_i),
        .core_rf_waddr_i  (core_rf_waddr_i),
        .core_rf_wdata_i  (core_rf_wdata_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .rf_busy_o        (rf_busy_o),
        .stall_id_o       (stall_id_o),
        .outstanding_o    (outstanding_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every RF write must match the head of the expected queue
    always @(negedge clk_i) begin
        if (rf_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rf_write: got x%0d=%h expected no write", rf_waddr_o, rf_wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, e.addr});
                check("rf_wdata", rf_wdata_o, e.data);
            end
        end
    end

    task automatic idle();
        x_issue_accept_i = 1'b0;
        x_issue_we_i     = 1'b0;
        x_issue_rd_i     = '0;
        x_result_valid_i = 1'b0;
        x_result_we_i    = 1'b0;
        x_result_rd_i    = '0;
        x_result_data_i  = '0;
        core_rf_we_i     = 1'b0;
        core_rf_waddr_i  = '0;
        core_rf_wdata_i  = '0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic we);
        x_issue_accept_i = 1'b1;
        x_issue_we_i     = we;
        x_issue_rd_i     = rd;
    endtask

    task automatic result(input logic we, input logic [4:0] rd, input logic [31:0] d);
        x_result_valid_i = 1'b1;
        x_result_we_i    = we;
        x_result_rd_i    = rd;
        x_result_data_i  = d;
    endtask

    task automatic core_wr(input logic [4:0] a, input logic [31:0] d);
        core_rf_we_i    = 1'b1;
        core_rf_waddr_i = a;
        core_rf_wdata_i = d;
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        repeat (2) cyc();
        #1;
        check("rst_result_ready", {31'd0, x_result_ready_o}, 32'd0);
        check("rst_issue_ready", {31'd0, issue_ready_o}, 32'd0);
        rst_ni = 1'b1;
        #1;
        check("init_outstanding", {29'd0, outstanding_o}, 32'd0);
        check("init_busy", rf_busy_o, 32'd0);
        check("init_stall", {31'd0, stall_id_o}, 32'd0);
        check("init_result_ready", {31'd0, x_result_ready_o}, 32'd1);
        check("init_issue_ready", {31'd0, issue_ready_o}, 32'd1);

        // Single result, core idle: write x5 the cycle after handshake
        cyc();
        issue(5'd5, 1'b1);
        cyc();
        check("t1_outstanding_1", {29'd0, outstanding_o}, 32'd1);
        check("t1_busy_set", rf_busy_o, 32'h0000_0020);
        result(1'b1, 5'd5, 32'hA5A5_0001);
        push_exp(5'd5, 32'hA5A5_0001);
        #1;
        check("t1_result_ready", {31'd0, x_result_ready_o}, 32'd1);
        cyc();
        check("t1_outstanding_0", {29'd0, outstanding_o}, 32'd0);
        check("t1_busy_held", rf_busy_o, 32'h0000_0020);
        cyc();
        check("t1_busy_clr", rf_busy_o, 32'd0);

        // Buffered x7 blocked by three core writes, written in the fourth cycle
        issue(5'd7, 1'b1);
        cyc();
        result(1'b1, 5'd7, 32'h7777_0007);
        cyc();
        core_wr(5'd3, 32'h3333_0003);
        #1;
        check("t2_ready_blk1", {31'd0, x_result_ready_o}, 32'd0);
        cyc();
        core_wr(5'd4, 32'h4444_0004);
        #1;
        check("t2_ready_blk2", {31'd0, x_result_ready_o}, 32'd0);
        cyc();
        core_wr(5'd6, 32'h6666_0006);
        #1;
        check("t2_ready_blk3", {31'd0, x_result_ready_o}, 32'd0);
        cyc();
        push_exp(5'd7, 32'h7777_0007);
        #1;
        check("t2_ready_drain", {31'd0, x_result_ready_o}, 32'd1);
        cyc();
        check("t2_busy_clr", rf_busy_o, 32'd0);
        check("t2_outstanding", {29'd0, outstanding_o}, 32'd0);

        // Starvation: stall after 8 blocked cycles, drops the cycle after drain
        issue(5'd10, 1'b1);
        cyc();
        result(1'b1, 5'd10, 32'h1010_0010);
        cyc();
        for (int k = 1; k <= 10; k++) begin
            core_wr(5'd1, 32'h0000_0100 + k);
            cyc();
            check($sformatf("t3_stall_after_%0d", k), {31'd0, stall_id_o}, (k >= 8) ? 32'd1 : 32'd0);
        end
        push_exp(5'd10, 32'h1010_0010);
        #1;
        check("t3_stall_in_drain", {31'd0, stall_id_o}, 32'd1);
        cyc();
        check("t3_stall_cleared", {31'd0, stall_id_o}, 32'd0);
        check("t3_busy_clr", rf_busy_o, 32'd0);

        // Fill to MaxOutstanding, then back-to-back results at one per cycle
        for (int i = 0; i < 4; i++) begin
            issue(5'(11 + i), 1'b1);
            cyc();
            check($sformatf("t4_outstanding_%0d", i + 1), {29'd0, outstanding_o}, 32'(i + 1));
        end
        #1;
        check("t4_issue_ready_full", {31'd0, issue_ready_o}, 32'd0);
        check("t4_busy_full", rf_busy_o, 32'h0000_7800);
        result(1'b1, 5'd11, 32'hB0B0_000B);
        push_exp(5'd11, 32'hB0B0_000B);
        cyc();
        check("t4_outstanding_3", {29'd0, outstanding_o}, 32'd3);
        check("t4_issue_ready_again", {31'd0, issue_ready_o}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            result(1'b1, 5'(11 + i), 32'hB0B0_0000 + 32'(11 + i));
            push_exp(5'(11 + i), 32'hB0B0_0000 + 32'(11 + i));
            #1;
            check($sformatf("t4_ready_b2b_%0d", i), {31'd0, x_result_ready_o}, 32'd1);
            cyc();
        end
        cyc();
        check("t4_outstanding_end", {29'd0, outstanding_o}, 32'd0);
        check("t4_busy_end", rf_busy_o, 32'd0);

        // Same-cycle issue and drain of rd 9: set wins
        issue(5'd9, 1'b1);
        cyc();
        result(1'b1, 5'd9, 32'h9999_0001);
        push_exp(5'd9, 32'h9999_0001);
        cyc();
        issue(5'd9, 1'b1);
        cyc();
        check("t5_busy9_kept", rf_busy_o, 32'h0000_0200);
        check("t5_outstanding_1", {29'd0, outstanding_o}, 32'd1);
        result(1'b1, 5'd9, 32'h9999_0002);
        push_exp(5'd9, 32'h9999_0002);
        cyc();
        check("t5_outstanding_0", {29'd0, outstanding_o}, 32'd0);
        cyc();
        check("t5_busy9_clr", rf_busy_o, 32'd0);

        // Result to x0: counter decrements, no RF write, x0 never busy
        issue(5'd0, 1'b1);
        cyc();
        check("t5_busy_r0", rf_busy_o, 32'd0);
        check("t5_outstanding_r0", {29'd0, outstanding_o}, 32'd1);
        result(1'b1, 5'd0, 32'hDEAD_0000);
        cyc();
        check("t5_outstanding_r0_dec", {29'd0, outstanding_o}, 32'd0);
        cyc();

        // Result with we=0 retires silently
        issue(5'd15, 1'b0);
        cyc();
        check("t5_busy_we0", rf_busy_o, 32'd0);
        result(1'b0, 5'd15, 32'hBAD0_000F);
        cyc();
        cyc();
        check("t5_outstanding_we0", {29'd0, outstanding_o}, 32'd0);

        // Reset with buffer full, stall raised and an offload in flight
        issue(5'd20, 1'b1);
        cyc();
        result(1'b1, 5'd20, 32'h2020_0020);
        cyc();
        for (int k = 1; k <= 8; k++) begin
            core_wr(5'd2, 32'h0000_0200 + k);
            if (k == 1) issue(5'd21, 1'b1);
            cyc();
        end
        check("t6_pre_stall", {31'd0, stall_id_o}, 32'd1);
        check("t6_pre_busy", rf_busy_o, 32'h0030_0000);
        check("t6_pre_outstanding", {29'd0, outstanding_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_result_ready", {31'd0, x_result_ready_o}, 32'd0);
        check("t6_rst_issue_ready", {31'd0, issue_ready_o}, 32'd0);
        cyc();
        rst_ni = 1'b1;
        #1;
        check("t6_post_result_ready", {31'd0, x_result_ready_o}, 32'd1);
        check("t6_post_busy", rf_busy_o, 32'd0);
        check("t6_post_outstanding", {29'd0, outstanding_o}, 32'd0);
        check("t6_post_stall", {31'd0, stall_id_o}, 32'd0);
        cyc();
        cyc();

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
